// File: rtl/dram_write_sequencer.sv
// dram_write_sequencer: clears a DRAM with FILL, then forwards user writes one per cycle.
// Optional clear sweep enabled by DRAM_WSEQ_CLEAR_EN; without it the block is ready one edge after reset.
module dram_write_sequencer #(
  parameter int                ADDR_W = 5,
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              clr_start,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              init_done,
  output logic [7:0]        wr_count
);
  logic              hs, sweep;
  logic [ADDR_W-1:0] sweep_addr;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
`ifdef DRAM_WSEQ_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clr_start) begin
      state_d = CLEAR;
      idx_d   = '0;
    end else if (state_q == CLEAR) begin
      idx_d   = idx_q + 1'b1;
      state_d = &idx_q ? READY : CLEAR;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  assign sweep      = state_q == CLEAR;
  assign sweep_addr = idx_q;
  assign init_done  = state_q == READY;
  assign req_ready  = init_done && !clr_start;
`else
  logic init_q, unused_clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end
  assign unused_clr = clr_start;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = init_q;
  assign req_ready  = init_q;
`endif
  // sweep and handshake are mutually exclusive since req_ready is low while sweeping
  always_comb begin
    hs      = req_valid && req_ready;
    we_d    = sweep || hs;
    waddr_d = sweep ? sweep_addr : hs ? req_addr : waddr_q;
    wdata_d = sweep ? FILL : hs ? req_data : wdata_q;
    cnt_d   = cnt_q + {7'd0, hs};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign wr_count  = cnt_q;
endmodule

// File: tb/tb_dram_write_sequencer.sv
// tb_dram_write_sequencer: randomized self-checking bench against a behavioural write model.
// Follows DRAM_WSEQ_CLEAR_EN so it matches whichever build it is compiled with.
module tb_dram_write_sequencer;
  localparam int          AW    = 5;
  localparam int          DW    = 16;
  localparam int          DEPTH = 1 << AW;
  localparam logic [DW-1:0] FILL = 16'h0000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, clr_start = 1'b0, req_ready;
  logic [AW-1:0] req_addr = '0, ram_waddr;
  logic [DW-1:0] req_data = '0, ram_wdata;
  logic          ram_we, init_done;
  logic [7:0]    wr_count;

  int checks = 0, passes = 0;
  logic rdy_seen, init_seen, exp_rdy, exp_init;

  logic          m_ready, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt, m_pos;

  dram_write_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .init_done(init_done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready(input logic c);
`ifdef DRAM_WSEQ_CLEAR_EN
    return m_ready && !c;
`else
    return m_ready;
`endif
  endfunction

  function automatic void model_reset();
    m_ready = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_pos = 0;
  endfunction

  function automatic void model_step(input logic v, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    acc = v && model_ready(c);
`ifdef DRAM_WSEQ_CLEAR_EN
    if (!m_ready) begin
      m_we = 1'b1; m_addr = AW'(m_pos); m_data = FILL;
      m_pos = c ? 0 : m_pos + 1;
      if (m_pos == DEPTH) begin m_ready = 1'b1; m_pos = 0; end
      return;
    end
    if (c) begin m_ready = 1'b0; m_pos = 0; m_we = 1'b0; return; end
`endif
    m_we = acc;
    if (acc) begin m_addr = a; m_data = d; m_cnt = (m_cnt + 1) % 256; end
    m_ready = 1'b1;
  endfunction

  task automatic cyc(input logic v, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v; clr_start = c; req_addr = a; req_data = d;
    #1;
    rdy_seen = req_ready; init_seen = init_done;
    exp_rdy = model_ready(c); exp_init = m_ready;
    @(posedge clk);
    model_step(v, c, a, d);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 1'b0; clr_start = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ram_we, ram_waddr, ram_wdata, wr_count, req_ready, init_done} !== '0)
      $display("FAIL reset_async: got %h required 0", {ram_we, ram_waddr, ram_wdata, wr_count, req_ready, init_done});
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({ram_we, req_ready, init_done} !== 3'b000)
      $display("FAIL reset_held: got %b required 000", {ram_we, req_ready, init_done});
    else passes++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
`ifdef DRAM_WSEQ_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 5'd3, 16'h1111);
      checks++;
      if ({ram_we, ram_waddr, ram_wdata, rdy_seen, init_seen} !== {1'b1, AW'(i), FILL, 2'b00})
        $display("FAIL sweep_%0d: got we=%b addr=%0d data=%h rdy=%b init=%b required we=1 addr=%0d data=%h rdy=0 init=0",
                 i, ram_we, ram_waddr, ram_wdata, rdy_seen, init_seen, i, FILL);
      else passes++;
    end
    req_valid = 1'b0; #1;
    checks++;
    if ({init_done, req_ready, wr_count} !== {2'b11, 8'd0})
      $display("FAIL init_end: got init=%b rdy=%b cnt=%0d required 1 1 0", init_done, req_ready, wr_count);
    else passes++;
`else
    cyc(1'b0, 1'b0, '0, '0);
    checks++;
    if ({init_seen, rdy_seen} !== 2'b00)
      $display("FAIL init_before_edge: got %b required 00", {init_seen, rdy_seen});
    else passes++;
    checks++;
    if ({init_done, req_ready, ram_we} !== 3'b110)
      $display("FAIL init_first_edge: got %b required 110", {init_done, req_ready, ram_we});
    else passes++;
`endif
  endtask

  task automatic test_burst();
    logic [AW-1:0] a [3] = '{5'd5, 5'd6, 5'd7};
    logic [DW-1:0] d [3] = '{16'hA5A5, 16'h5A5A, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, a[i], d[i]);
      checks++;
      if ({ram_we, ram_waddr, ram_wdata, rdy_seen} !== {1'b1, a[i], d[i], 1'b1})
        $display("FAIL burst_%0d: got we=%b addr=%0d data=%h rdy=%b required 1 %0d %h 1",
                 i, ram_we, ram_waddr, ram_wdata, rdy_seen, a[i], d[i]);
      else passes++;
    end
    cyc(1'b0, 1'b0, 5'd9, 16'h0123);
    checks++;
    if ({ram_we, ram_waddr, ram_wdata, wr_count} !== {1'b0, 5'd7, 16'hFFFF, 8'd3})
      $display("FAIL burst_idle: got we=%b addr=%0d data=%h cnt=%0d required 0 7 ffff 3",
               ram_we, ram_waddr, ram_wdata, wr_count);
    else passes++;
  endtask

  task automatic test_clr_priority();
    logic [7:0] cnt_exp;
    cnt_exp = 8'(m_cnt);
`ifdef DRAM_WSEQ_CLEAR_EN
    cyc(1'b1, 1'b1, 5'd9, 16'h1234);
    checks++;
    if ({rdy_seen, ram_we, wr_count} !== {2'b00, cnt_exp})
      $display("FAIL clr_priority: got rdy=%b we=%b cnt=%0d required 0 0 %0d", rdy_seen, ram_we, wr_count, cnt_exp);
    else passes++;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 5'd9, 16'h1234);
      checks++;
      if ({ram_we, ram_waddr, ram_wdata, wr_count} !== {1'b1, AW'(i), FILL, cnt_exp})
        $display("FAIL clr_sweep_%0d: got we=%b addr=%0d cnt=%0d required 1 %0d %0d", i, ram_we, ram_waddr, wr_count, i, cnt_exp);
      else passes++;
    end
`else
    cyc(1'b0, 1'b1, 5'd9, 16'h1234);
    checks++;
    if ({rdy_seen, ram_we, init_done, wr_count} !== {3'b101, cnt_exp})
      $display("FAIL clr_ignored: got rdy=%b we=%b init=%b cnt=%0d required 1 0 1 %0d", rdy_seen, ram_we, init_done, wr_count, cnt_exp);
    else passes++;
`endif
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 1'b0, 5'd21, 16'hBEEF);
    rst_n = 1'b0; #1;
    checks++;
    if ({ram_we, ram_waddr, ram_wdata, wr_count, req_ready, init_done} !== '0)
      $display("FAIL midwrite_reset: got %h required 0", {ram_we, ram_waddr, ram_wdata, wr_count, req_ready, init_done});
    else passes++;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
`ifdef DRAM_WSEQ_CLEAR_EN
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0; #1;
    checks++;
    if ({ram_we, ram_waddr, ram_wdata, req_ready, init_done} !== '0)
      $display("FAIL sweep17_reset: got %h required 0", {ram_we, ram_waddr, ram_wdata, req_ready, init_done});
    else passes++;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b0, '0, '0);
      checks++;
      if ({ram_we, ram_waddr, init_seen} !== {1'b1, AW'(i), 1'b0})
        $display("FAIL resweep_%0d: got we=%b addr=%0d init=%b required 1 %0d 0", i, ram_we, ram_waddr, init_seen, i);
      else passes++;
    end
`endif
    cyc(1'b0, 1'b0, '0, '0);
    checks++;
    if ({init_done, ram_we} !== 2'b10)
      $display("FAIL post_reset_ready: got %b required 10", {init_done, ram_we});
    else passes++;
  endtask

  task automatic test_random();
    logic v, c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 39) == 0;
      a = AW'($urandom);
      d = DW'($urandom);
      cyc(v, c, a, d);
      checks++;
      if ({rdy_seen, init_seen} !== {exp_rdy, exp_init})
        $display("FAIL rand_ctl_%0d: got rdy=%b init=%b required %b %b", i, rdy_seen, init_seen, exp_rdy, exp_init);
      else passes++;
      checks++;
      if ({ram_we, ram_waddr, ram_wdata, wr_count} !== {m_we, m_addr, m_data, 8'(m_cnt)})
        $display("FAIL rand_out_%0d: got we=%b addr=%0d data=%h cnt=%0d required %b %0d %h %0d",
                 i, ram_we, ram_waddr, ram_wdata, wr_count, m_we, m_addr, m_data, m_cnt);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    int guard;
    apply_reset();
    guard = 0;
    while (!m_ready && guard < 4 * DEPTH) begin cyc(1'b0, 1'b0, '0, '0); guard++; end
    checks++;
    if (init_done !== 1'b1) $display("FAIL wrap_init: got %b required 1", init_done);
    else passes++;
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, AW'(i), DW'(i));
    checks++;
    if (wr_count !== 8'd0) $display("FAIL wrap_256: got %0d required 0", wr_count);
    else passes++;
    cyc(1'b1, 1'b0, 5'd1, 16'h0101);
    checks++;
    if (wr_count !== 8'd1) $display("FAIL wrap_257: got %0d required 1", wr_count);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_burst();
    test_clr_priority();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
